// File: rtl/wb_pkg.sv
// Shared constants and types for the Wishbone burst master.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DONE
   } state_t;

endpackage

// File: rtl/wb_beat_timer.sv
// Per-beat wait watchdog: down-counter reloaded with TIMEOUT, terminal count flags an abort.
module wb_beat_timer
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic sys_clk,
   input  logic wb_rst_i,
   input  logic load,
   input  logic count_en,
   output logic expire
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT);

   logic [TW-1:0] cnt;

   // Reload at the start of every beat; count down only on genuine wait cycles.
   always_ff @(posedge sys_clk) begin
      if (wb_rst_i || load) begin
         cnt <= T_LOAD;
      end else if (count_en && (cnt != '0)) begin
         cnt <= cnt - TW'(1);
      end
   end

   // The TIMEOUT-th consecutive wait cycle is the one that aborts.
   always_comb begin
      expire = count_en && (cnt == TW'(1));
   end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: one command in, one burst out, done/err per command.
//
//   state | meaning
//   IDLE  | cmd_ready high, bus idle, waiting for a command
//   BURST | cyc high, beats issued until last ack, error or timeout
//   DONE  | bus released, done pulse (err flags an abort), back to IDLE
module wb_burst_master
   import wb_pkg::*;
#(
   parameter int DW        = 32,
   parameter int AW        = 26,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 255,
   localparam int LW       = $clog2(MAX_BURST + 1),
   localparam int SW       = DW / 8
) (
   input  logic          sys_clk,
   input  logic          wb_rst_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          cmd_we,
   input  logic          wd_valid,
   output logic          wd_ready,
   input  logic [DW-1:0] wd_data,
   input  logic [SW-1:0] wd_sel,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          done,
   output logic          err,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [AW-1:0] wb_addr_o,
   output logic [DW-1:0] wb_dat_o,
   output logic [SW-1:0] wb_sel_o,
   output logic [2:0]    wb_cti_o,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic [DW-1:0] wb_dat_i
);

   state_t        state, state_nx;
   logic [AW-1:0] addr_r;
   logic [LW-1:0] len_r;
   logic [LW-1:0] rem_r;
   logic          we_r;
   logic          err_r;
   logic          hold_v;
   logic [DW-1:0] hold_data;
   logic [SW-1:0] hold_sel;

   logic in_burst;
   logic accept;
   logic beat_ack;
   logic beat_err;
   logic last_beat;
   logic expire;
   logic abort;
   logic wd_take;

   // Bus handshake decode; err dominates ack, and either is ignored without stb.
   always_comb begin
      in_burst  = (state == BURST);
      cmd_ready = (state == IDLE);
      accept    = cmd_valid && cmd_ready;
      wb_cyc_o  = in_burst;
      wb_stb_o  = in_burst && (!we_r || hold_v);
      wb_we_o   = in_burst && we_r;
      beat_err  = wb_stb_o && wb_err_i;
      beat_ack  = wb_stb_o && wb_ack_i && !wb_err_i;
      last_beat = (rem_r == LW'(1));
      abort     = beat_err || expire;
      // Refill the hold register only while some beat still lacks data.
      wd_ready  = in_burst && we_r && (!hold_v || (beat_ack && !last_beat));
      wd_take   = wd_valid && wd_ready;
   end

   // Write data starvation stalls stb, so it never counts towards a timeout.
   wb_beat_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_beat_timer (
      .sys_clk  (sys_clk),
      .wb_rst_i (wb_rst_i),
      .load     (accept || beat_ack),
      .count_en (wb_stb_o && !wb_ack_i && !wb_err_i),
      .expire   (expire)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and completion outputs.
   always_comb begin
      state_nx = state;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = BURST;
            end
         end
         BURST: begin
            if (abort || (beat_ack && last_beat)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            err      = err_r;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command latch, address walk and remaining-beat count.
   always_ff @(posedge sys_clk) begin
      if (wb_rst_i) begin
         addr_r <= '0;
         len_r  <= '0;
         rem_r  <= '0;
         we_r   <= 1'b0;
         err_r  <= 1'b0;
      end else if (accept) begin
         addr_r <= cmd_addr;
         len_r  <= (cmd_len == '0) ? LW'(1) : cmd_len;
         rem_r  <= (cmd_len == '0) ? LW'(1) : cmd_len;
         we_r   <= cmd_we;
         err_r  <= 1'b0;
      end else if (in_burst && abort) begin
         rem_r  <= '0;
         err_r  <= 1'b1;
      end else if (beat_ack) begin
         addr_r <= addr_r + AW'(SW);
         rem_r  <= rem_r - LW'(1);
      end
   end

   // One-entry write hold register, flushed whenever no burst is running.
   always_ff @(posedge sys_clk) begin
      if (wb_rst_i || !in_burst || abort) begin
         hold_v    <= 1'b0;
         hold_data <= '0;
         hold_sel  <= '0;
      end else if (wd_take) begin
         hold_v    <= 1'b1;
         hold_data <= wd_data;
         hold_sel  <= wd_sel;
      end else if (beat_ack) begin
         hold_v    <= 1'b0;
      end
   end

   // Read beats are forwarded one cycle after their ack.
   always_ff @(posedge sys_clk) begin
      if (wb_rst_i) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= beat_ack && !we_r;
         rd_last  <= beat_ack && !we_r && last_beat;
         if (beat_ack && !we_r) begin
            rd_data <= wb_dat_i;
         end
      end
   end

   // Bus-side address, data, byte enables and cycle type.
   always_comb begin
      wb_addr_o = addr_r;
      wb_dat_o  = hold_data;
      wb_sel_o  = '0;
      wb_cti_o  = CTI_CLASSIC;
      if (in_burst) begin
         wb_sel_o = we_r ? hold_sel : '1;
         if (len_r != LW'(1)) begin
            wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master with a behavioural Wishbone slave.
module tb_wb_burst_master;

   localparam int DW = 32;
   localparam int AW = 26;
   localparam int MB = 16;
   localparam int TO = 8;
   localparam int LW = 5;
   localparam int SW = 4;

   logic          sys_clk = 1'b0;
   logic          wb_rst_i;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          cmd_we;
   logic          wd_valid;
   logic          wd_ready;
   logic [DW-1:0] wd_data;
   logic [SW-1:0] wd_sel;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          done;
   logic          err;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_we_o;
   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic [2:0]    wb_cti_o;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic [DW-1:0] wb_dat_i;

   always #5 sys_clk = ~sys_clk;

   wb_burst_master #(
      .DW        (DW),
      .AW        (AW),
      .MAX_BURST (MB),
      .TIMEOUT   (TO)
   ) dut (
      .sys_clk   (sys_clk),
      .wb_rst_i  (wb_rst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_we    (cmd_we),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .wd_sel    (wd_sel),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .done      (done),
      .err       (err),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_addr_o (wb_addr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_sel_o  (wb_sel_o),
      .wb_cti_o  (wb_cti_o),
      .wb_ack_i  (wb_ack_i),
      .wb_err_i  (wb_err_i),
      .wb_dat_i  (wb_dat_i)
   );

   typedef struct { logic [65:0] key; int cyc; } beat_t;
   typedef struct { logic [32:0] v;   int cyc; } rd_t;
   typedef struct { logic e;          int cyc; } done_t;

   logic [65:0] exp_beat_q[$];
   logic [32:0] exp_rd_q[$];
   beat_t       obs_beat_q[$];
   rd_t         obs_rd_q[$];
   done_t       obs_done_q[$];

   int total = 0;
   int passed = 0;
   int cycle = 0;
   int cyc_hi = 0;
   int stall_cnt = 0;
   int slave_mode = 0;
   int err_beat = 0;
   int slave_beat = 0;

   function automatic logic [65:0] beat_key(logic [AW-1:0] a, logic [2:0] c, logic w,
                                            logic [3:0] s, logic [31:0] d);
      return {a, c, w, s, (w ? d : 32'h0)};
   endfunction

   function automatic logic [31:0] rd_model(logic [AW-1:0] a);
      return 32'hC0DE_0000 ^ {6'h0, a};
   endfunction

   function automatic logic [2:0] exp_cti(int len, int i);
      if (len == 1) return 3'b000;
      return (i == len - 1) ? 3'b111 : 3'b010;
   endfunction

   // Slave: mode 0 acks every strobe, 1 never answers, 2 errs on beat err_beat, 3 ack+err there.
   always_comb begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
         case (slave_mode)
            0: wb_ack_i = 1'b1;
            2: begin
               if (slave_beat == err_beat) wb_err_i = 1'b1;
               else wb_ack_i = 1'b1;
            end
            3: begin
               wb_ack_i = 1'b1;
               if (slave_beat == err_beat) wb_err_i = 1'b1;
            end
            default: ;
         endcase
      end
      wb_dat_i = rd_model(wb_addr_o);
   end

   always @(posedge sys_clk) begin
      cycle <= cycle + 1;
      if (!wb_cyc_o) slave_beat <= 0;
      else if (wb_stb_o && (wb_ack_i || wb_err_i)) slave_beat <= slave_beat + 1;
   end

   // Monitor: records accepted beats, read beats and completions with their cycle number.
   always @(negedge sys_clk) begin
      beat_t b;
      rd_t   r;
      done_t d;
      if (!wb_rst_i) begin
         if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
            b.key = beat_key(wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_dat_o);
            b.cyc = cycle;
            obs_beat_q.push_back(b);
         end
         if (rd_valid) begin
            r.v = {rd_last, rd_data};
            r.cyc = cycle;
            obs_rd_q.push_back(r);
         end
         if (done) begin
            d.e = err;
            d.cyc = cycle;
            obs_done_q.push_back(d);
         end
         if (wb_cyc_o) cyc_hi++;
         if (wb_cyc_o && !wb_stb_o) stall_cnt++;
      end
   end

   task automatic clear_obs();
      exp_beat_q.delete();
      exp_rd_q.delete();
      obs_beat_q.delete();
      obs_rd_q.delete();
      obs_done_q.delete();
      cyc_hi = 0;
      stall_cnt = 0;
   endtask

   task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge sys_clk); #1;
         n++;
      end
      cmd_addr = a;
      cmd_len = l;
      cmd_we = w;
      cmd_valid = 1'b1;
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic push_read_exp(input logic [AW-1:0] a, input int len, input int nb);
      for (int i = 0; i < nb; i++) begin
         exp_beat_q.push_back(beat_key(a + AW'(4 * i), exp_cti(len, i), 1'b0, 4'hF, 32'h0));
         exp_rd_q.push_back({(i == len - 1), rd_model(a + AW'(4 * i))});
      end
   endtask

   task automatic feed_write(input logic [AW-1:0] a, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         logic [31:0] d;
         logic [3:0]  s;
         logic        acc;
         int          k;
         d = 32'hD000_0000 + i * 32'h0101;
         s = 4'(i * 5 + 3);
         exp_beat_q.push_back(beat_key(a + AW'(4 * i), exp_cti(n, i), 1'b1, s, d));
         repeat (gap) begin @(posedge sys_clk); #1; end
         wd_valid = 1'b1;
         wd_data = d;
         wd_sel = s;
         k = 0;
         acc = 1'b0;
         while (!acc && k < 100) begin
            @(negedge sys_clk);
            acc = wd_ready;
            @(posedge sys_clk); #1;
            k++;
         end
         wd_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input int n, output bit ok);
      int k = 0;
      while (obs_done_q.size() < n && k < 300) begin
         @(posedge sys_clk); #1;
         k++;
      end
      ok = (obs_done_q.size() >= n);
      @(posedge sys_clk); #1;
   endtask

   task automatic test_reset();
      logic [76:0] got;
      wb_rst_i = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      got = {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
             cmd_ready, wd_ready, rd_valid, rd_last, done, err};
      total++;
      if (got !== {3'b000, 26'h0, 32'h0, 4'h0, 3'h0, 1'b1, 5'b00000})
         $display("FAIL reset_outputs got %h want cmd_ready only", got);
      else passed++;
      @(posedge sys_clk); #1;
      wb_rst_i = 1'b0;
   endtask

   task automatic test_read_burst();
      bit ok;
      int bc[4];
      clear_obs();
      slave_mode = 0;
      push_read_exp(26'h100, 4, 4);
      issue_cmd(26'h100, 5'd4, 1'b0);
      total++;
      if (cmd_ready !== 1'b0) $display("FAIL rd4_cmd_ready_busy got %b want 0", cmd_ready);
      else passed++;
      wait_done(1, ok);
      total++;
      if (!ok) $display("FAIL rd4_done_timeout got none want done");
      else passed++;
      for (int i = 0; i < 4; i++) begin
         logic [65:0] e;
         beat_t o;
         rd_t r;
         e = exp_beat_q.pop_front();
         total++;
         if (obs_beat_q.size() == 0) begin
            $display("FAIL rd4_beat%0d got none want %h", i, e);
            bc[i] = -10;
         end else begin
            o = obs_beat_q.pop_front();
            bc[i] = o.cyc;
            if (o.key !== e || (i > 0 && o.cyc !== bc[0] + i))
               $display("FAIL rd4_beat%0d got %h@%0d want %h", i, o.key, o.cyc, e);
            else passed++;
         end
         total++;
         if (obs_rd_q.size() == 0) $display("FAIL rd4_data%0d got none want %h", i, exp_rd_q[0]);
         else begin
            r = obs_rd_q.pop_front();
            if (r.v !== exp_rd_q[0] || r.cyc !== bc[i] + 1)
               $display("FAIL rd4_data%0d got %h@%0d want %h@%0d", i, r.v, r.cyc, exp_rd_q[0], bc[i] + 1);
            else passed++;
         end
         void'(exp_rd_q.pop_front());
      end
      total++;
      if (obs_done_q.size() == 0) $display("FAIL rd4_done got none want err=0");
      else if (obs_done_q[0].e !== 1'b0 || obs_done_q[0].cyc !== bc[3] + 1)
         $display("FAIL rd4_done got err=%b@%0d want err=0@%0d", obs_done_q[0].e, obs_done_q[0].cyc, bc[3] + 1);
      else passed++;
   endtask

   task automatic test_write_gaps();
      bit ok;
      clear_obs();
      slave_mode = 0;
      issue_cmd(26'h200, 5'd3, 1'b1);
      feed_write(26'h200, 3, 2);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b0) $display("FAIL wr3_done got ok=%b want done err=0", ok);
      else passed++;
      total++;
      if (stall_cnt < 3) $display("FAIL wr3_stb_gaps got %0d stalls want >=3", stall_cnt);
      else passed++;
      while (exp_beat_q.size() > 0) begin
         logic [65:0] e;
         beat_t o;
         e = exp_beat_q.pop_front();
         total++;
         if (obs_beat_q.size() == 0) $display("FAIL wr3_beat got none want %h", e);
         else begin
            o = obs_beat_q.pop_front();
            if (o.key !== e) $display("FAIL wr3_beat got %h want %h", o.key, e);
            else passed++;
         end
      end
      total++;
      if (obs_beat_q.size() + obs_rd_q.size() != 0)
         $display("FAIL wr3_extra got %0d events want 0", obs_beat_q.size() + obs_rd_q.size());
      else passed++;
      // Starve the data path far longer than TIMEOUT: must not abort.
      clear_obs();
      issue_cmd(26'h280, 5'd2, 1'b1);
      feed_write(26'h280, 2, 12);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b0 || obs_beat_q.size() != 2)
         $display("FAIL wr_starve got ok=%b beats=%0d want err=0 beats=2", ok, obs_beat_q.size());
      else passed++;
   endtask

   task automatic test_single();
      bit ok;
      clear_obs();
      slave_mode = 0;
      issue_cmd(26'h800, 5'd1, 1'b1);
      feed_write(26'h800, 1, 0);
      push_read_exp(26'h804, 1, 1);
      wait_done(1, ok);
      issue_cmd(26'h804, 5'd0, 1'b0);
      wait_done(2, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b0 || obs_done_q[1].e !== 1'b0)
         $display("FAIL single_done got ok=%b want two done err=0", ok);
      else passed++;
      while (exp_beat_q.size() > 0) begin
         logic [65:0] e;
         beat_t o;
         e = exp_beat_q.pop_front();
         total++;
         if (obs_beat_q.size() == 0) $display("FAIL single_beat got none want %h", e);
         else begin
            o = obs_beat_q.pop_front();
            if (o.key !== e) $display("FAIL single_beat got %h want %h", o.key, e);
            else passed++;
         end
      end
      total++;
      if (obs_rd_q.size() != 1 || obs_rd_q[0].v !== exp_rd_q[0])
         $display("FAIL single_rd got %0d beats want 1 value %h", obs_rd_q.size(), exp_rd_q[0]);
      else passed++;
   endtask

   task automatic test_timeout();
      bit ok;
      clear_obs();
      slave_mode = 1;
      issue_cmd(26'h040, 5'd2, 1'b0);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b1) $display("FAIL timeout_done got ok=%b want done err=1", ok);
      else passed++;
      total++;
      if (cyc_hi != TO) $display("FAIL timeout_cyc_len got %0d want %0d", cyc_hi, TO);
      else passed++;
      total++;
      if (obs_beat_q.size() + obs_rd_q.size() != 0)
         $display("FAIL timeout_no_data got %0d want 0", obs_beat_q.size() + obs_rd_q.size());
      else passed++;
   endtask

   task automatic test_bus_error();
      bit ok;
      clear_obs();
      slave_mode = 2;
      err_beat = 1;
      push_read_exp(26'h300, 4, 1);
      issue_cmd(26'h300, 5'd4, 1'b0);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b1) $display("FAIL err_done got ok=%b want done err=1", ok);
      else passed++;
      total++;
      if (obs_rd_q.size() != 1 || obs_rd_q[0].v !== exp_rd_q[0])
         $display("FAIL err_rd got %0d beats want 1 value %h", obs_rd_q.size(), exp_rd_q[0]);
      else passed++;
      clear_obs();
      slave_mode = 3;
      err_beat = 0;
      issue_cmd(26'h340, 5'd3, 1'b0);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b1 || obs_rd_q.size() != 0)
         $display("FAIL ackerr_wins got ok=%b rd=%0d want err=1 rd=0", ok, obs_rd_q.size());
      else passed++;
      slave_mode = 0;
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      clear_obs();
      slave_mode = 1;
      issue_cmd(26'h500, 5'd4, 1'b0);
      repeat (3) begin @(posedge sys_clk); #1; end
      wb_rst_i = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      total++;
      if ({wb_cyc_o, cmd_ready, done} !== 3'b010)
         $display("FAIL midrst_state got cyc,rdy,done=%b want 010", {wb_cyc_o, cmd_ready, done});
      else passed++;
      @(posedge sys_clk); #1;
      wb_rst_i = 1'b0;
      repeat (12) begin @(posedge sys_clk); #1; end
      total++;
      if (obs_done_q.size() != 0) $display("FAIL midrst_no_done got %0d want 0", obs_done_q.size());
      else passed++;
      clear_obs();
      slave_mode = 0;
      push_read_exp(26'h3FF_FFF8, 3, 3);
      issue_cmd(26'h3FF_FFF8, 5'd3, 1'b0);
      wait_done(1, ok);
      total++;
      if (!ok || obs_done_q[0].e !== 1'b0) $display("FAIL wrap_done got ok=%b want err=0", ok);
      else passed++;
      while (exp_beat_q.size() > 0) begin
         logic [65:0] e;
         beat_t o;
         e = exp_beat_q.pop_front();
         total++;
         if (obs_beat_q.size() == 0) $display("FAIL wrap_beat got none want %h", e);
         else begin
            o = obs_beat_q.pop_front();
            if (o.key !== e) $display("FAIL wrap_beat got %h want %h", o.key, e);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int bc[4];
      clear_obs();
      slave_mode = 0;
      push_read_exp(26'h600, 2, 2);
      push_read_exp(26'h700, 2, 2);
      issue_cmd(26'h600, 5'd2, 1'b0);
      issue_cmd(26'h700, 5'd2, 1'b0);
      wait_done(2, ok);
      total++;
      if (!ok) $display("FAIL b2b_done got %0d done want 2", obs_done_q.size());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         logic [65:0] e;
         beat_t o;
         e = exp_beat_q.pop_front();
         bc[i] = -10;
         total++;
         if (obs_beat_q.size() == 0) $display("FAIL b2b_beat%0d got none want %h", i, e);
         else begin
            o = obs_beat_q.pop_front();
            bc[i] = o.cyc;
            if (o.key !== e) $display("FAIL b2b_beat%0d got %h want %h", i, o.key, e);
            else passed++;
         end
      end
      total++;
      if (obs_done_q.size() == 0 || bc[2] !== obs_done_q[0].cyc + 2)
         $display("FAIL b2b_gap got beat@%0d want two cycles after first done", bc[2]);
      else passed++;
   endtask

   initial begin
      wb_rst_i = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr = '0;
      cmd_len = '0;
      cmd_we = 1'b0;
      wd_valid = 1'b0;
      wd_data = '0;
      wd_sel = '0;
      test_reset();
      test_read_burst();
      test_write_gaps();
      test_single();
      test_timeout();
      test_bus_error();
      test_reset_mid_burst();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
